// File: rtl/io_pkg.sv
// Shared types and default sizing for the IN/OUT responder.
// Compile with +define+IO_ECHO_EN to echo each IN value onto the display.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } io_state_t;

  localparam int IO_DATA_W          = 32;
  localparam int IO_SW_W            = 16;
  localparam int IO_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus run-length counter for the raw enter button.
// stable_valid is high once the current level has been seen DEBOUNCE_CYCLES times in a row.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic stable_level,
  output logic stable_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // A changed sample is the first of a new run, so the count restarts at one.
      if (sync_p1 != level) begin
        level <= sync_p1;
        cnt   <= CNT_W'(1);
      end else begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  assign stable_level = level;
  assign stable_valid = (cnt == CNT_MAX);

endmodule

// File: rtl/io_responder.sv
// Responder for IN (stall until enter pressed and released, return switches) and OUT (load display).
// Optional IO_ECHO_EN: a completed IN also copies its value onto the display.
module io_responder
  import io_pkg::*;
#(
  parameter int DATA_W          = IO_DATA_W,
  parameter int SW_W            = IO_SW_W,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              op_io,
  input  logic              req_in,
  input  logic              req_out,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_enter,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_update
);

  io_state_t state;
  logic      armed;
  logic      btn_level;
  logic      btn_valid;
  logic      in_req;
  logic      out_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn         (btn_enter),
    .stable_level(btn_level),
    .stable_valid(btn_valid)
  );

  assign in_req  = op_io & req_in;
  assign out_req = op_io & req_out & ~req_in;
  assign stall   = in_req & (state != DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      in_data     <= '0;
      in_valid    <= 1'b0;
      disp_value  <= '0;
      disp_update <= 1'b0;
    end else begin
      in_valid    <= 1'b0;
      disp_update <= 1'b0;
      case (state)
        IDLE: begin
          if (in_req) begin
            state <= WAIT_PRESS;
            armed <= 1'b0;
          end else if (out_req) begin
            disp_value  <= out_data;
            disp_update <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          // A press only counts after a stable release, so a button held at request time is ignored.
          if (!in_req) begin
            state <= IDLE;
          end else if (btn_valid && !btn_level) begin
            armed <= 1'b1;
          end else if (armed && btn_valid && btn_level) begin
            state   <= WAIT_RELEASE;
            in_data <= DATA_W'(sw);
          end
        end
        WAIT_RELEASE: begin
          if (!in_req) begin
            state <= IDLE;
          end else if (btn_valid && !btn_level) begin
            state    <= DONE;
            in_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef IO_ECHO_EN
          disp_value  <= in_data;
          disp_update <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
